// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared types and defaults for the fetch sequencing controller.
// Holds the sequencer state enum, redirect source indices and parameter defaults.
package fetch_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    DRAIN  = 2'd2,
    SWITCH = 2'd3
  } fetch_seq_state_t;

  // Redirect source indices double as redirect_ack bit positions and priority order.
  localparam int SRC_COMMIT = 0;
  localparam int SRC_EXEC   = 1;
  localparam int SRC_DEC    = 2;

  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int MAX_INFLIGHT_DEF = 4;

endpackage

// File: rtl/fetch_redirect_arb.sv
// Three-way fixed-priority redirect select (commit > exec > dec), purely combinational.
// Zero latency; losers receive no ack and are expected to hold their request.
module fetch_redirect_arb
  import fetch_seq_ctrl_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            i_commit_vld,
  input  logic [size-1:0] i_commit_pc,
  input  logic            i_exec_vld,
  input  logic [size-1:0] i_exec_pc,
  input  logic            i_dec_vld,
  input  logic [size-1:0] i_dec_pc,
  output logic            o_mispred,
  output logic [size-1:0] o_pc,
  output logic [2:0]      o_ack
);

  always_comb begin
    o_mispred = 1'b0;
    o_pc      = '0;
    o_ack     = 3'b000;
    if (i_commit_vld) begin
      o_mispred         = 1'b1;
      o_pc              = i_commit_pc;
      o_ack[SRC_COMMIT] = 1'b1;
    end else if (i_exec_vld) begin
      o_mispred       = 1'b1;
      o_pc            = i_exec_pc;
      o_ack[SRC_EXEC] = 1'b1;
    end else if (i_dec_vld) begin
      o_mispred      = 1'b1;
      o_pc           = i_dec_pc;
      o_ack[SRC_DEC] = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: redirect arbitration, post-redirect flush, in-flight throttling and
// drained fetch-width switching. Optional counters enabled by FETCH_SEQ_STATS_EN.
module fetch_seq_ctrl
  import fetch_seq_ctrl_pkg::*;
#(
  parameter int   size           = 32,
  parameter int   FLUSH_CYCLES   = FLUSH_CYCLES_DEF,
  parameter int   MAX_INFLIGHT   = MAX_INFLIGHT_DEF,
  parameter logic PARALLEL_RESET = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            commit_redirect_valid,
  input  logic [size-1:0] commit_redirect_pc,
  input  logic            exec_redirect_valid,
  input  logic [size-1:0] exec_redirect_pc,
  input  logic            dec_redirect_valid,
  input  logic [size-1:0] dec_redirect_pc,
  output logic [2:0]      redirect_ack,
  input  logic            fetch_ready,
  input  logic            fetch_retire,
  input  logic            mode_req_valid,
  input  logic            mode_req_parallel,
  output logic            mode_ack,
  output logic            mode_busy,
  output logic            misprediction,
  output logic [size-1:0] correct_pc,
  output logic            buble,
  output logic            parallel_mode,
  output logic            flush_fetch,
`ifdef FETCH_SEQ_STATS_EN
  output logic [31:0]     redirect_count,
  output logic [31:0]     stall_count,
`endif
  output logic [3:0]      inflight
);

  fetch_seq_state_t r_state;
  logic [2:0]       r_cnt;
  logic [3:0]       r_inflight;
  logic             r_pend;
  logic             r_pend_val;
  logic             r_parallel;
  logic             r_mode_ack;
  logic             r_flush;

  logic             w_mis;
  logic [size-1:0]  w_pc;
  logic [2:0]       w_ack;
  logic             w_stall;
  logic             w_buble;
  logic             w_issue;
  logic             w_retire;
  logic             w_mode_take;
  logic             w_mode_same;
  logic             w_mode_latch;
  logic             w_pend_next;

  fetch_redirect_arb #(.size(size)) u_arb (
    .i_commit_vld (commit_redirect_valid),
    .i_commit_pc  (commit_redirect_pc),
    .i_exec_vld   (exec_redirect_valid),
    .i_exec_pc    (exec_redirect_pc),
    .i_dec_vld    (dec_redirect_valid),
    .i_dec_pc     (dec_redirect_pc),
    .o_mispred    (w_mis),
    .o_pc         (w_pc),
    .o_ack        (w_ack)
  );

  // A redirect always lifts the PC hold so the new target is taken immediately.
  assign w_stall  = !fetch_ready || (r_inflight == 4'(MAX_INFLIGHT)) ||
                    (r_state == DRAIN) || (r_state == SWITCH);
  assign w_buble  = w_stall && !w_mis;
  assign w_issue  = !w_buble && !w_mis && ((r_state == RUN) || (r_state == FLUSH));
  assign w_retire = fetch_retire && (r_inflight != 4'd0);

  // Requests are only taken in RUN/FLUSH; a same-width request in RUN is a no-op ack.
  assign w_mode_take  = mode_req_valid && !r_pend && ((r_state == RUN) || (r_state == FLUSH));
  assign w_mode_same  = w_mode_take && (r_state == RUN) && (mode_req_parallel == r_parallel);
  assign w_mode_latch = w_mode_take && !w_mode_same;
  assign w_pend_next  = r_pend || w_mode_latch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= RUN;
      r_cnt      <= 3'd0;
      r_inflight <= 4'd0;
      r_pend     <= 1'b0;
      r_pend_val <= 1'b0;
      r_parallel <= PARALLEL_RESET;
      r_mode_ack <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_mode_ack <= w_mode_same;
      if (w_mode_latch) begin
        r_pend     <= 1'b1;
        r_pend_val <= mode_req_parallel;
      end

      if (w_mis) begin
        r_inflight <= 4'd0;
      end else if (w_issue && !w_retire) begin
        r_inflight <= r_inflight + 4'd1;
      end else if (!w_issue && w_retire) begin
        r_inflight <= r_inflight - 4'd1;
      end

      if (w_mis) begin
        r_state <= FLUSH;
        r_cnt   <= 3'(FLUSH_CYCLES);
        r_flush <= 1'b1;
      end else begin
        case (r_state)
          RUN: begin
            if (w_mode_latch) r_state <= DRAIN;
          end
          FLUSH: begin
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt <= 3'd1) begin
              r_state <= w_pend_next ? DRAIN : RUN;
              r_flush <= 1'b0;
            end
          end
          DRAIN: begin
            if (r_inflight == 4'd0) r_state <= SWITCH;
          end
          SWITCH: begin
            r_parallel <= r_pend_val;
            r_pend     <= 1'b0;
            r_mode_ack <= 1'b1;
            r_state    <= RUN;
          end
          default: r_state <= RUN;
        endcase
      end
    end
  end

`ifdef FETCH_SEQ_STATS_EN
  logic [31:0] r_redirect_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_redirect_count <= 32'd0;
      r_stall_count    <= 32'd0;
    end else begin
      if (w_mis)   r_redirect_count <= r_redirect_count + 32'd1;
      if (w_buble) r_stall_count    <= r_stall_count + 32'd1;
    end
  end

  assign redirect_count = r_redirect_count;
  assign stall_count    = r_stall_count;
`endif

  assign redirect_ack  = w_ack;
  assign misprediction = w_mis;
  assign correct_pc    = w_pc;
  assign buble         = w_buble;
  assign mode_ack      = r_mode_ack;
  assign mode_busy     = r_pend;
  assign parallel_mode = r_parallel;
  assign flush_fetch   = r_flush;
  assign inflight      = r_inflight;

endmodule

// File: doc/fetch_seq_ctrl.md
FETCH_SEQ_CTRL -- requirements
Module: fetch_seq_ctrl

Interface
REQ-001 Parameter: size, 32, address width.
REQ-002 Parameter: FLUSH_CYCLES, 2, cycles fetch output squashed after a redirect (range 1..7).
REQ-003 Parameter: MAX_INFLIGHT, 4, maximum fetch groups issued but not consumed (range 1..15).
REQ-004 Parameter: PARALLEL_RESET, 1'b0, parallel_mode value after reset.
REQ-005 Ports, clock and reset first:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- commit_redirect_valid / commit_redirect_pc  in  1 / size  redirect from commit, priority 0 (highest)
- exec_redirect_valid / exec_redirect_pc  in  1 / size  redirect from execute, priority 1
- dec_redirect_valid / dec_redirect_pc  in  1 / size  redirect from decode, priority 2
- redirect_ack  out  3  one-hot, bit i = source i accepted this cycle
- fetch_ready  in  1  decode buffer can accept a fetch group
- fetch_retire  in  1  decode consumed one fetch group
- mode_req_valid / mode_req_parallel  in  1 / 1  request a parallel_mode change
- mode_ack  out  1  one-cycle pulse, request completed
- mode_busy  out  1  mode change pending
- misprediction / correct_pc  out  1 / size  redirect to the PC controller
- buble  out  1  hold the PC
- parallel_mode  out  1  registered fetch width select
- flush_fetch  out  1  squash the fetch-stage output
- inflight  out  4  outstanding fetch groups

Function
REQ-006 Redirect arbitration SHALL be combinational and fixed-priority (commit > exec > dec), with zero latency: misprediction=1 and correct_pc=the winner's pc in the same cycle; otherwise correct_pc=0.
REQ-007 A redirect SHALL be accepted in every state. Losing same-cycle sources get no ack and the requester SHALL hold valid.
REQ-008 States: RUN, FLUSH, DRAIN, SWITCH, encoded per the package enum.
REQ-009 On an accepted redirect, the next state SHALL be FLUSH, the flush counter SHALL load FLUSH_CYCLES, and inflight SHALL clear to 0 at the next edge.
REQ-010 FLUSH: flush_fetch=1. The counter decrements each cycle. At count 1 the next state SHALL be DRAIN if a mode change is pending, else RUN. A redirect during FLUSH SHALL reload the counter.
REQ-011 buble = !fetch_ready | (inflight==MAX_INFLIGHT) | state==DRAIN | state==SWITCH, except buble SHALL be 0 whenever misprediction=1.
REQ-012 A fetch is issued in a cycle when buble=0, misprediction=0 and state is RUN or FLUSH. Issue increments inflight; fetch_retire decrements it. Simultaneous issue and retire SHALL leave inflight unchanged. A retire at 0 SHALL be ignored (saturate at 0).
REQ-013 mode_req_valid in RUN with mode_req_parallel==parallel_mode: mode_ack SHALL pulse next cycle and nothing else changes.
REQ-014 mode_req_valid in RUN with a different value: the value SHALL be latched, mode_busy=1, and the next state SHALL be DRAIN.
REQ-015 mode_req_valid in FLUSH: the request SHALL be latched and made pending.
REQ-016 mode_req_valid while mode_busy=1 SHALL be ignored.
REQ-017 DRAIN: when inflight==0, the next state SHALL be SWITCH.
REQ-018 SWITCH (one cycle): parallel_mode SHALL load the pending value at the exit edge, the next state SHALL be RUN, mode_ack SHALL pulse in the first RUN cycle, and mode_busy SHALL clear.
REQ-019 A redirect in DRAIN or SWITCH SHALL take precedence (next state FLUSH); the pending mode SHALL be retained.

Reset
REQ-020 On reset low: state RUN, counter 0, inflight 0, no mode pending, parallel_mode=PARALLEL_RESET, mode_ack=0, flush_fetch=0. Combinational outputs follow their equations.
REQ-021 Reset asserted mid-DRAIN or mid-FLUSH SHALL discard the pending mode and any remaining flush cycles.

Configuration
REQ-022 Macro FETCH_SEQ_STATS_EN defined: add outputs redirect_count (32 bits, counts accepted redirects) and stall_count (32 bits, counts cycles with buble=1). Both SHALL wrap at 2^32 and clear on reset.
REQ-023 Macro undefined: those ports and counters SHALL be absent, with behaviour otherwise identical.

Structure
REQ-024 The shared package SHALL hold the fetch_seq_state_t enum (RUN, FLUSH, DRAIN, SWITCH), the redirect source index constants, and the FLUSH_CYCLES/MAX_INFLIGHT defaults.
REQ-025 One sub-module SHALL be used: fetch_redirect_arb (3-way fixed-priority select producing misprediction, correct_pc and redirect_ack). All other logic SHALL be inline.

Verification
REQ-026 Simultaneous commit_pc=0x100 and exec_pc=0x200: misprediction=1, correct_pc=0x100, redirect_ack=3'b001 in the same cycle, then flush_fetch=1 for exactly 2 cycles.
REQ-027 fetch_ready=1, no retire for 6 cycles: inflight counts 1..4, then buble=1 with inflight held at 4; a single fetch_retire lets one more issue occur.
REQ-028 parallel_mode=0, inflight=3, request 1: mode_busy=1 and buble=1; after 3 retires, SWITCH; parallel_mode=1 and mode_ack pulses one cycle later.
REQ-029 exec redirect during DRAIN: FLUSH for 2 cycles, inflight=0, then DRAIN, then SWITCH; the mode is applied.
REQ-030 Reset pulsed in FLUSH with a mode pending: all state cleared, parallel_mode=PARALLEL_RESET, mode_busy=0, and no mode_ack ever pulses.
